// File: rtl/enc_pkg.sv
`default_nettype none
//==============================================================================
// Module      : enc_pkg
// Description : Shared quadrature types and the edge-decode helper.
// Revision    : 1.0 - initial release
//==============================================================================
package enc_pkg;

    typedef logic [1:0] quad_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_CW   = 2'd1,
        DIR_CCW  = 2'd2,
        DIR_ILL  = 2'd3
    } dir_t;

    // Map {a,b} onto its position in the CW cycle 00,10,11,01 and compare
    // positions: +1 is CW, -1 is CCW, 2 means both bits flipped.
    function automatic dir_t quad_decode(input quad_t prev, input quad_t cur);
        logic [1:0] p_ph;
        logic [1:0] c_ph;
        logic [1:0] delta;
        p_ph  = {prev[0], prev[1] ^ prev[0]};
        c_ph  = {cur[0], cur[1] ^ cur[0]};
        delta = c_ph - p_ph;
        case (delta)
            2'd1:    return DIR_CW;
            2'd3:    return DIR_CCW;
            2'd2:    return DIR_ILL;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_channel.sv
`default_nettype none
//==============================================================================
// Module      : quad_channel
// Description : One encoder channel: synchroniser, priming, decode, detent
//               sub-count and position. ENC_ERR_DETECT_EN enables err pulses.
// Revision    : 1.0 - initial release
//==============================================================================
module quad_channel
    import enc_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int STEPS_DET = 4,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic             cw,
    output logic             ccw,
    output logic             err,
    output logic [CNT_W-1:0] pos
);

    localparam logic signed [3:0] c_SUB_TOP = 4'(STEPS_DET - 1);
    localparam logic signed [3:0] c_SUB_BOT = -c_SUB_TOP;
    localparam logic [CNT_W-1:0]  c_POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0]  c_POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  c_POS_ONE = CNT_W'(1);

    quad_t             r_sync1_q;
    quad_t             r_sync2_q;
    quad_t             r_prev_q;
    logic              r_primed_q, w_primed_d;
    logic signed [3:0] r_sub_q,    w_sub_d;
    logic [CNT_W-1:0]  r_pos_q,    w_pos_d;
    logic              r_cw_q,     w_cw_d;
    logic              r_ccw_q,    w_ccw_d;
    logic              r_err_q,    w_err_d;
    dir_t              w_dir;

    // Synchroniser and prev keep following the pins through reset and clr,
    // so the levels present at reset release never decode as a step.
    always_ff @(posedge clk) begin
        r_sync1_q <= {a, b};
        r_sync2_q <= r_sync1_q;
        r_prev_q  <= r_sync2_q;
    end

    always_comb begin
        w_dir      = quad_decode(r_prev_q, r_sync2_q);
        w_primed_d = 1'b1;
        w_sub_d    = r_sub_q;
        w_pos_d    = r_pos_q;
        w_cw_d     = 1'b0;
        w_ccw_d    = 1'b0;
        w_err_d    = 1'b0;
        if (r_primed_q) begin
            case (w_dir)
                DIR_CW: begin
                    if (r_sub_q == c_SUB_TOP) begin
                        w_cw_d  = 1'b1;
                        w_sub_d = '0;
                        if (SATURATE == 0 || r_pos_q != c_POS_MAX)
                            w_pos_d = r_pos_q + c_POS_ONE;
                    end else begin
                        w_sub_d = r_sub_q + 4'sd1;
                    end
                end
                DIR_CCW: begin
                    if (r_sub_q == c_SUB_BOT) begin
                        w_ccw_d = 1'b1;
                        w_sub_d = '0;
                        if (SATURATE == 0 || r_pos_q != c_POS_MIN)
                            w_pos_d = r_pos_q - c_POS_ONE;
                    end else begin
                        w_sub_d = r_sub_q - 4'sd1;
                    end
                end
                DIR_ILL: begin
`ifdef ENC_ERR_DETECT_EN
                    w_err_d = 1'b1;
`else
                    w_err_d = 1'b0;
`endif
                end
                default: ;
            endcase
        end
        if (clr) begin
            w_pos_d = '0;
            w_sub_d = '0;
            w_cw_d  = 1'b0;
            w_ccw_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_primed_q <= 1'b0;
            r_sub_q    <= '0;
            r_pos_q    <= '0;
            r_cw_q     <= 1'b0;
            r_ccw_q    <= 1'b0;
            r_err_q    <= 1'b0;
        end else begin
            r_primed_q <= w_primed_d;
            r_sub_q    <= w_sub_d;
            r_pos_q    <= w_pos_d;
            r_cw_q     <= w_cw_d;
            r_ccw_q    <= w_ccw_d;
            r_err_q    <= w_err_d;
        end
    end

    assign cw  = r_cw_q;
    assign ccw = r_ccw_q;
    assign err = r_err_q;
    assign pos = r_pos_q;

endmodule
`default_nettype wire

// File: rtl/quad_encoder_counter.sv
`default_nettype none
//==============================================================================
// Module      : quad_encoder_counter
// Description : N_CH independent quadrature encoder channels with position and
//               detent pulses. ENC_ERR_DETECT_EN enables illegal-edge err pulses.
// Revision    : 1.0 - initial release
//==============================================================================
module quad_encoder_counter
    import enc_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int CNT_W     = 16,
    parameter int STEPS_DET = 4,
    parameter int SATURATE  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_CH-1:0]       a,
    input  logic [N_CH-1:0]       b,
    input  logic [N_CH-1:0]       clr,
    output logic [N_CH-1:0]       cw,
    output logic [N_CH-1:0]       ccw,
    output logic [N_CH*CNT_W-1:0] pos,
    output logic [N_CH-1:0]       err
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        quad_channel #(
            .CNT_W     (CNT_W),
            .STEPS_DET (STEPS_DET),
            .SATURATE  (SATURATE)
        ) u_channel (
            .clk     (clk),
            .reset_n (reset_n),
            .a       (a[i]),
            .b       (b[i]),
            .clr     (clr[i]),
            .cw      (cw[i]),
            .ccw     (ccw[i]),
            .err     (err[i]),
            .pos     (pos[i*CNT_W +: CNT_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_counter.sv
`default_nettype none
//==============================================================================
// Module      : tb_quad_encoder_counter
// Description : Directed bench for quad_encoder_counter (16-bit wrap, 4-bit wrap
//               and 4-bit saturating instances on shared stimulus).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_quad_encoder_counter;

    localparam int N_CH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic [N_CH-1:0] a, b, clr;
    logic [N_CH-1:0] cw_m, ccw_m, err_m, cw_w, ccw_w, err_w, cw_s, ccw_s, err_s;
    logic [31:0]     pos_m;
    logic [7:0]      pos_w, pos_s;

    quad_encoder_counter #(.N_CH(N_CH), .CNT_W(16), .STEPS_DET(4), .SATURATE(0)) u_dut_m (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .clr(clr),
        .cw(cw_m), .ccw(ccw_m), .pos(pos_m), .err(err_m));
    quad_encoder_counter #(.N_CH(N_CH), .CNT_W(4), .STEPS_DET(4), .SATURATE(0)) u_dut_w (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .clr(clr),
        .cw(cw_w), .ccw(ccw_w), .pos(pos_w), .err(err_w));
    quad_encoder_counter #(.N_CH(N_CH), .CNT_W(4), .STEPS_DET(4), .SATURATE(1)) u_dut_s (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .clr(clr),
        .cw(cw_s), .ccw(ccw_s), .pos(pos_s), .err(err_s));

`ifdef ENC_ERR_DETECT_EN
    localparam int c_ERR_ON = 1;
`else
    localparam int c_ERR_ON = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0]      s_ab [N_CH];
    logic [N_CH-1:0] s_clr;
    logic            s_rst_n;
    logic            s_valid = 1'b0;

    always @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) s_ab[c] <= {a[c], b[c]};
        s_clr   <= clr;
        s_rst_n <= reset_n;
        s_valid <= 1'b1;
    end

    function automatic int cycle_pos(input logic [1:0] v);
        logic [1:0] order [4];
        order = '{2'b00, 2'b10, 2'b11, 2'b01};
        for (int k = 0; k < 4; k++) if (order[k] == v) return k;
        return 0;
    endfunction

    function automatic int wrapv(input int x, input int w);
        int span, r;
        span = 1 << w;
        r = (x + span / 2) % span;
        if (r < 0) r += span;
        return r - span / 2;
    endfunction

    function automatic int satv(input int x, input int w);
        if (x > (1 << (w - 1)) - 1) return (1 << (w - 1)) - 1;
        if (x < -(1 << (w - 1)))    return -(1 << (w - 1));
        return x;
    endfunction

    logic [1:0] hist [N_CH][4];
    int m_sub [N_CH], m_p16 [N_CH], m_p4w [N_CH], m_p4s [N_CH];
    int m_cw [N_CH], m_ccw [N_CH], m_err [N_CH];
    int m_primed = 0;
    int cnt_cw [N_CH], cnt_ccw [N_CH], cnt_err [N_CH], cnt_cw_s1 = 0;

    initial begin
        for (int c = 0; c < N_CH; c++) begin
            cnt_cw[c] = 0; cnt_ccw[c] = 0; cnt_err[c] = 0;
        end
        forever begin
            @(negedge clk);
            if (s_valid) begin
                for (int c = 0; c < N_CH; c++) begin
                    hist[c][3] = hist[c][2]; hist[c][2] = hist[c][1];
                    hist[c][1] = hist[c][0]; hist[c][0] = s_ab[c];
                end
                if (!s_rst_n) begin
                    m_primed = 0;
                    for (int c = 0; c < N_CH; c++) begin
                        m_sub[c] = 0; m_p16[c] = 0; m_p4w[c] = 0; m_p4s[c] = 0;
                        m_cw[c] = 0; m_ccw[c] = 0; m_err[c] = 0;
                    end
                end else begin
                    for (int c = 0; c < N_CH; c++) begin
                        int step;
                        m_cw[c] = 0; m_ccw[c] = 0; m_err[c] = 0;
                        step = (cycle_pos(hist[c][2]) - cycle_pos(hist[c][3]) + 4) % 4;
                        if (m_primed != 0) begin
                            if (step == 2) m_err[c] = c_ERR_ON;
                            if (step == 1) m_sub[c]++;
                            if (step == 3) m_sub[c]--;
                            if (m_sub[c] == 4 || m_sub[c] == -4) begin
                                int d;
                                d = (m_sub[c] > 0) ? 1 : -1;
                                if (d > 0) m_cw[c] = 1; else m_ccw[c] = 1;
                                m_sub[c] = 0;
                                m_p16[c] = wrapv(m_p16[c] + d, 16);
                                m_p4w[c] = wrapv(m_p4w[c] + d, 4);
                                m_p4s[c] = satv(m_p4s[c] + d, 4);
                            end
                        end
                        if (s_clr[c]) begin
                            m_sub[c] = 0; m_p16[c] = 0; m_p4w[c] = 0; m_p4s[c] = 0;
                            m_cw[c] = 0; m_ccw[c] = 0;
                        end
                    end
                    m_primed = 1;
                end
                for (int c = 0; c < N_CH; c++) begin
                    check($sformatf("cw16[%0d]", c),  cw_m[c],  m_cw[c]);
                    check($sformatf("ccw16[%0d]", c), ccw_m[c], m_ccw[c]);
                    check($sformatf("err16[%0d]", c), err_m[c], m_err[c]);
                    check($sformatf("pos16[%0d]", c), longint'($signed(pos_m[c*16 +: 16])), m_p16[c]);
                    check($sformatf("cw4w[%0d]", c),  cw_w[c],  m_cw[c]);
                    check($sformatf("ccw4w[%0d]", c), ccw_w[c], m_ccw[c]);
                    check($sformatf("pos4w[%0d]", c), longint'($signed(pos_w[c*4 +: 4])), m_p4w[c]);
                    check($sformatf("cw4s[%0d]", c),  cw_s[c],  m_cw[c]);
                    check($sformatf("ccw4s[%0d]", c), ccw_s[c], m_ccw[c]);
                    check($sformatf("err4s[%0d]", c), err_s[c], m_err[c]);
                    check($sformatf("pos4s[%0d]", c), longint'($signed(pos_s[c*4 +: 4])), m_p4s[c]);
                    cnt_cw[c]  += int'(cw_m[c]);
                    cnt_ccw[c] += int'(ccw_m[c]);
                    cnt_err[c] += int'(err_m[c]);
                end
                cnt_cw_s1 += int'(cw_s[1]);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] l0, l1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic move(input logic [1:0] n0, input logic [1:0] n1);
        l0 = n0; l1 = n1;
        a = {l1[1], l0[1]};
        b = {l1[0], l0[0]};
        tick(2);
    endtask

    task automatic pulse_clr(input logic [N_CH-1:0] m);
        clr = m; tick(1); clr = '0; tick(2);
    endtask

    function automatic longint p16(input int c);
        return longint'($signed(pos_m[c*16 +: 16]));
    endfunction

    initial begin
        int snap_cw0, snap_ccw0, snap_err0, snap_ccw1, snap_cws;
        reset_n = 1'b0; clr = '0; l0 = 2'b11; l1 = 2'b11;
        a = 2'b11; b = 2'b11;
        tick(4);
        reset_n = 1'b1;
        tick(20);
        check("t1 pos0 after idle", p16(0), 0);
        check("t1 pulses after idle", cnt_cw[0] + cnt_cw[1] + cnt_ccw[0] + cnt_ccw[1], 0);

        reset_n = 1'b0;
        move(2'b00, 2'b00);
        tick(3);
        reset_n = 1'b1;
        tick(4);

        snap_cw0 = cnt_cw[0];
        move(2'b10, 2'b00); move(2'b11, 2'b00); move(2'b01, 2'b00); move(2'b00, 2'b00);
        tick(4);
        check("t2 pos0 one cw detent", p16(0), 1);
        check("t2 cw0 pulse count", cnt_cw[0] - snap_cw0, 1);

        pulse_clr(2'b01);
        snap_cw0 = cnt_cw[0]; snap_ccw0 = cnt_ccw[0];
        repeat (2) begin
            move(2'b01, 2'b00); move(2'b11, 2'b00); move(2'b10, 2'b00); move(2'b00, 2'b00);
        end
        move(2'b10, 2'b00); move(2'b11, 2'b00); move(2'b01, 2'b00);
        move(2'b11, 2'b00);
        tick(4);
        check("t3 pos0 two ccw detents", p16(0), -2);
        check("t3 ccw0 count", cnt_ccw[0] - snap_ccw0, 2);
        check("t3 cw0 count", cnt_cw[0] - snap_cw0, 0);

        pulse_clr(2'b10);
        snap_cws = cnt_cw_s1;
        repeat (7) begin
            move(l0, 2'b10); move(l0, 2'b11); move(l0, 2'b01); move(l0, 2'b00);
        end
        tick(4);
        check("t4 pos4w at max", longint'($signed(pos_w[7:4])), 7);
        move(l0, 2'b10); move(l0, 2'b11); move(l0, 2'b01); move(l0, 2'b00);
        tick(4);
        check("t4 pos4w wrapped", longint'($signed(pos_w[7:4])), -8);
        check("t4 pos4s held", longint'($signed(pos_s[7:4])), 7);
        repeat (7) begin
            move(l0, 2'b10); move(l0, 2'b11); move(l0, 2'b01); move(l0, 2'b00);
        end
        tick(4);
        check("t4 pos4w after 15", longint'($signed(pos_w[7:4])), -1);
        check("t4 pos4s after 15", longint'($signed(pos_s[7:4])), 7);
        check("t4 pos16 ch1", p16(1), 15);
        check("t4 sat cw pulses", cnt_cw_s1 - snap_cws, 15);

        pulse_clr(2'b01);
        snap_cw0 = cnt_cw[0];
        move(2'b01, l1); move(2'b00, l1); move(2'b10, l1);
        l0 = 2'b11;
        a = {l1[1], l0[1]}; b = {l1[0], l0[0]};
        tick(2);
        clr = 2'b01; tick(1); clr = '0;
        tick(4);
        check("t5 clr beats detent pos0", p16(0), 0);
        check("t5 clr beats detent cw0", cnt_cw[0] - snap_cw0, 0);

        pulse_clr(2'b11);
        snap_err0 = cnt_err[0];
        move(2'b00, 2'b00);
        tick(4);
        check("t6 illegal no step pos0", p16(0), 0);
        check("t6 err0 count", cnt_err[0] - snap_err0, c_ERR_ON);
        snap_cw0 = cnt_cw[0]; snap_ccw1 = cnt_ccw[1];
        move(2'b10, 2'b01); move(2'b11, 2'b11); move(2'b01, 2'b10); move(2'b00, 2'b00);
        tick(4);
        check("t6 concurrent pos0", p16(0), 1);
        check("t6 concurrent pos1", p16(1), -1);
        check("t6 concurrent cw0", cnt_cw[0] - snap_cw0, 1);
        check("t6 concurrent ccw1", cnt_ccw[1] - snap_ccw1, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
